// File: rtl/l1i_cache_if.sv
// Backing-memory word handshake between the L1 instruction cache and the
// next level. The cache is the master: it raises a request with a word
// address and the memory returns one word per acknowledged cycle.
interface l1i_cache_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache with 1-cycle hit latency and a
// word-by-word line refill from backing memory.
// Optional feature macro: L1I_PERF_CNT_EN adds hit/miss counters
// (hit_cnt_o, miss_cnt_o). Without it those ports do not exist.
module l1i_cache #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        hold_flag_i,
  input  logic        jump_flag_i,
  input  logic        flush_i,
  input  logic        pc_re_i,
  input  logic [31:0] pc_raddr_i,
  output logic [31:0] pc_rdata_o,
  output logic [31:0] pc_raddr_o,
  output logic        pc_valid_o,
  output logic        pc_stall_o,
`ifdef L1I_PERF_CNT_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  l1i_cache_if.master mem
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic              kill_q, kill_d;          // jump seen during refill: drop the response
  logic              flush_pend_q, flush_pend_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_addr_q, out_addr_d;
  logic              out_ram_q, out_ram_d;    // 1: word comes from the data-array read port
  logic [31:0]       word_q, word_d;          // missed word captured during refill

  // Storage arrays (not reset)
  logic [TAG_W-1:0]  tag_mem [SETS];
  logic [31:0]       data_mem [SETS*LINE_WORDS];
  logic [31:0]       ram_rd_q;

  // Address fields of the incoming fetch and of the latched miss
  logic [OFF_W-1:0]  lk_off, m_off;
  logic [IDX_W-1:0]  lk_idx, m_idx;
  logic [TAG_W-1:0]  lk_tag, m_tag;

  assign lk_off = pc_raddr_i[OFF_W+1:2];
  assign lk_idx = pc_raddr_i[OFF_W+IDX_W+1:OFF_W+2];
  assign lk_tag = pc_raddr_i[31:OFF_W+IDX_W+2];
  assign m_off  = miss_addr_q[OFF_W+1:2];
  assign m_idx  = miss_addr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign m_tag  = miss_addr_q[31:OFF_W+IDX_W+2];

  logic lookup, hit, svc_hit, svc_miss, ack_fire, data_we, tag_we;

  // Tags are read asynchronously so the hit decision is made in the request cycle.
  assign lookup   = (state_q == IDLE) && pc_re_i && !hold_flag_i && !jump_flag_i && !flush_i;
  assign hit      = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign svc_hit  = lookup && hit;
  assign svc_miss = lookup && !hit;
  assign ack_fire = (state_q == REFILL) && mem.mem_ack_i;

  // Data array: registered read for the hit path, refill writes one word per ack
  always_ff @(posedge clk) begin
    ram_rd_q <= data_mem[{lk_idx, lk_off}];
    if (data_we) data_mem[{m_idx, beat_q}] <= mem.mem_rdata_i;
    if (tag_we)  tag_mem[m_idx] <= m_tag;
  end

  // Next-state and output-register decisions for the IDLE/REFILL/RESP controller
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_addr_d  = miss_addr_q;
    kill_d       = kill_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    out_valid_d  = 1'b0;
    out_addr_d   = '0;
    out_ram_d    = 1'b0;
    word_d       = word_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          valid_d = '0;
        end else if (svc_hit) begin
          out_valid_d = 1'b1;
          out_addr_d  = pc_raddr_i;
          out_ram_d   = 1'b1;
        end else if (svc_miss) begin
          miss_addr_d = pc_raddr_i;
          beat_d      = '0;
          kill_d      = 1'b0;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        if (jump_flag_i) kill_d = 1'b1;
        if (flush_i)     flush_pend_d = 1'b1;
        if (ack_fire) begin
          data_we = 1'b1;
          if (beat_q == m_off) word_d = mem.mem_rdata_i;
          if (beat_q == LAST_BEAT) begin
            tag_we         = 1'b1;
            valid_d[m_idx] = 1'b1;
            beat_d         = '0;
            state_d        = RESP;
            if (!(kill_q || jump_flag_i || hold_flag_i)) begin
              out_valid_d = 1'b1;
              out_addr_d  = miss_addr_q;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      RESP: begin
        // A flush that arrived during the miss also drops the line just installed.
        if (flush_pend_q || flush_i) valid_d = '0;
        flush_pend_d = 1'b0;
        kill_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      miss_addr_q  <= '0;
      kill_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_ram_q    <= 1'b0;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_addr_q  <= miss_addr_d;
      kill_q       <= kill_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_ram_q    <= out_ram_d;
      word_q       <= word_d;
    end
  end

  // Outputs are forced to zero whenever they are not valid
  assign pc_valid_o     = out_valid_q;
  assign pc_raddr_o     = out_valid_q ? out_addr_q : '0;
  assign pc_rdata_o     = !out_valid_q ? '0 : (out_ram_q ? ram_rd_q : word_q);
  assign pc_stall_o     = (state_q != IDLE);
  assign mem.mem_req_o  = (state_q == REFILL);
  assign mem.mem_addr_o = (state_q == REFILL) ? {miss_addr_q[31:OFF_W+2], beat_q, 2'b00} : '0;

`ifdef L1I_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Serviced-hit and refill-started counters, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (svc_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (svc_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1i_cache.sv
// Self-checking bench for l1i_cache (SETS=64, LINE_WORDS=4): directed
// sequences, a table of single-cycle vectors and a randomized fetch stream
// checked against a set/tag reference model and a static backing memory.
module tb_l1i_cache;
  localparam int SETS = 64;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold_flag_i = 1'b0, jump_flag_i = 1'b0, flush_i = 1'b0;
  logic        pc_re_i = 1'b0;
  logic [31:0] pc_raddr_i = '0;
  logic [31:0] pc_rdata_o, pc_raddr_o;
  logic        pc_valid_o, pc_stall_o;
`ifdef L1I_PERF_CNT_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  l1i_cache_if mem_if ();

  l1i_cache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold_flag_i (hold_flag_i),
    .jump_flag_i (jump_flag_i),
    .flush_i     (flush_i),
    .pc_re_i     (pc_re_i),
    .pc_raddr_i  (pc_raddr_i),
    .pc_rdata_o  (pc_rdata_o),
    .pc_raddr_o  (pc_raddr_o),
    .pc_valid_o  (pc_valid_o),
    .pc_stall_o  (pc_stall_o),
`ifdef L1I_PERF_CNT_EN
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o),
`endif
    .mem         (mem_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference model: which line each set holds
  logic        mvalid [SETS];
  logic [31:0] mtag   [SETS];

  logic        ack_always = 1'b1;
  logic [31:0] acked [$];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> 10;
  endfunction

  // Backing memory contents: fixed pattern, with 0xA0..0xA3 at 0x100..0x10C
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    if (a >= 32'h100 && a <= 32'h10C) w = 32'hA0 + ((a - 32'h100) >> 2);
    else w = {a[15:0] ^ 16'h5A5A, a[15:0]};
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: acks requests (always or randomly) and watches address stability
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 1'b0;
    prev_addr = '0;
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_if.mem_ack_i   = 1'b0;
        mem_if.mem_rdata_i = '0;
        prev_wait = 1'b0;
      end else begin
        if (prev_wait && mem_if.mem_req_o) chk("addr_stable", mem_if.mem_addr_o, prev_addr);
        if (mem_if.mem_req_o && (ack_always || $urandom_range(0, 2) == 0)) begin
          mem_if.mem_ack_i   = 1'b1;
          mem_if.mem_rdata_i = memword(mem_if.mem_addr_o);
          acked.push_back(mem_if.mem_addr_o);
          prev_wait = 1'b0;
        end else begin
          mem_if.mem_ack_i   = 1'b0;
          mem_if.mem_rdata_i = $urandom;
          prev_wait = mem_if.mem_req_o;
          prev_addr = mem_if.mem_addr_o;
        end
      end
    end
  end

  // One fetch; hit or miss is predicted by the model, refill traffic and response checked
  task automatic fetch(input logic [31:0] a, input logic h, input logic fl_mid);
    logic        hit;
    logic [31:0] base;
    int          n;
    hit  = mvalid[idx_of(a)] && (mtag[idx_of(a)] == tag_of(a));
    base = a & ~32'hF;
    @(negedge clk);
    pc_re_i = 1'b1; pc_raddr_i = a; hold_flag_i = h;
    acked.delete();
    @(negedge clk);
    pc_re_i = 1'b0; hold_flag_i = 1'b0; pc_raddr_i = $urandom;
    if (h) begin
      chk("hold_valid", {31'd0, pc_valid_o}, 0);
      chk("hold_rdata", pc_rdata_o, 0);
      chk("hold_stall", {31'd0, pc_stall_o}, 0);
    end else if (hit) begin
      exp_hits++;
      chk("hit_valid", {31'd0, pc_valid_o}, 1);
      chk("hit_rdata", pc_rdata_o, memword(a));
      chk("hit_raddr", pc_raddr_o, a);
      chk("hit_memreq", {31'd0, mem_if.mem_req_o}, 0);
      chk("hit_stall", {31'd0, pc_stall_o}, 0);
    end else begin
      exp_misses++;
      chk("miss_stall", {31'd0, pc_stall_o}, 1);
      chk("miss_valid", {31'd0, pc_valid_o}, 0);
      if (fl_mid) begin
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
      end
      n = 0;
      while (!pc_valid_o && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("resp_valid", {31'd0, pc_valid_o}, 1);
      chk("resp_rdata", pc_rdata_o, memword(a));
      chk("resp_raddr", pc_raddr_o, a);
      chk("resp_stall", {31'd0, pc_stall_o}, 1);
      chk("beat_count", acked.size(), LW);
      for (int i = 0; i < LW && i < acked.size(); i++)
        chk("beat_addr", acked[i], base + 32'(4 * i));
      mvalid[idx_of(a)] = 1'b1;
      mtag[idx_of(a)]   = tag_of(a);
      if (fl_mid) model_clear();
      @(negedge clk);
      chk("post_stall", {31'd0, pc_stall_o}, 0);
      chk("post_valid", {31'd0, pc_valid_o}, 0);
      chk("post_memreq", {31'd0, mem_if.mem_req_o}, 0);
    end
    $display("fetch addr=%h hold=%0d hit=%0d", a, h, hit);
  endtask

  task automatic flush_pulse(input logic re, input logic [31:0] a);
    @(negedge clk);
    flush_i = 1'b1; pc_re_i = re; pc_raddr_i = a;
    @(negedge clk);
    flush_i = 1'b0; pc_re_i = 1'b0;
    chk("flush_valid", {31'd0, pc_valid_o}, 0);
    chk("flush_memreq", {31'd0, mem_if.mem_req_o}, 0);
    chk("flush_stall", {31'd0, pc_stall_o}, 0);
    model_clear();
    $display("flush re=%0d addr=%h", re, a);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        hold;
    logic        jump;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          n;
    logic        saw;
    logic [31:0] a;
    int          r;

    model_clear();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, pc_valid_o}, 0);
    chk("rst_stall", {31'd0, pc_stall_o}, 0);
    chk("rst_memreq", {31'd0, mem_if.mem_req_o}, 0);
    chk("rst_rdata", pc_rdata_o, 0);
    rst = 1'b1;

    // Cold miss, then hit in the same line
    fetch(32'h100, 1'b0, 1'b0);
    fetch(32'h108, 1'b0, 1'b0);
`ifdef L1I_PERF_CNT_EN
    chk("cnt_hit_1", hit_cnt_o, 1);
    chk("cnt_miss_1", miss_cnt_o, 1);
`endif
    // Eviction through a conflicting tag
    fetch(32'h500, 1'b0, 1'b0);
    fetch(32'h100, 1'b0, 1'b0);

    // Single-cycle vectors with line 0x100 resident
    vecs[0] = '{32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA2};
    vecs[1] = '{32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{32'h10C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};
    vecs[4] = '{32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA3};
    vecs[5] = '{32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pc_re_i = vecs[i].re; pc_raddr_i = vecs[i].addr;
      hold_flag_i = vecs[i].hold; jump_flag_i = vecs[i].jump; flush_i = vecs[i].flush;
      @(negedge clk);
      pc_re_i = 1'b0; hold_flag_i = 1'b0; jump_flag_i = 1'b0; flush_i = 1'b0;
      chk("vec_valid", {31'd0, pc_valid_o}, {31'd0, vecs[i].exp_valid});
      chk("vec_rdata", pc_rdata_o, vecs[i].exp_data);
      chk("vec_raddr", pc_raddr_o, vecs[i].exp_valid ? vecs[i].addr : 32'h0);
      chk("vec_memreq", {31'd0, mem_if.mem_req_o}, 0);
      if (vecs[i].exp_valid) exp_hits++;
      if (vecs[i].flush) model_clear();
      $display("vec %0d addr=%h valid=%0d data=%h", i, vecs[i].addr, pc_valid_o, pc_rdata_o);
    end

    // Jump during beat 1 of a miss: no response, but the line is installed
    ack_always = 1'b1;
    @(negedge clk);
    pc_re_i = 1'b1; pc_raddr_i = 32'h200;
    acked.delete();
    @(negedge clk);
    pc_re_i = 1'b0;
    exp_misses++;
    @(negedge clk);
    jump_flag_i = 1'b1;
    @(negedge clk);
    jump_flag_i = 1'b0;
    n = 0; saw = 1'b0;
    while (pc_stall_o && n < 100) begin
      if (pc_valid_o) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("jump_no_resp", {31'd0, saw}, 0);
    chk("jump_stall_end", {31'd0, pc_stall_o}, 0);
    chk("jump_beats", acked.size(), LW);
    mvalid[idx_of(32'h200)] = 1'b1;
    mtag[idx_of(32'h200)]   = tag_of(32'h200);
    $display("jump during refill of 200 beats=%0d", acked.size());
    fetch(32'h204, 1'b0, 1'b0);

    // Flush pulse in IDLE, then flush during refill
    flush_pulse(1'b0, 32'h0);
    fetch(32'h100, 1'b0, 1'b0);
    fetch(32'h300, 1'b0, 1'b1);
    fetch(32'h300, 1'b0, 1'b0);

    // Randomized fetch stream against the model
    ack_always = 1'b0;
    for (int i = 0; i < 120; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      r = $urandom_range(0, 15);
      if (r == 0) flush_pulse($urandom_range(0, 1) == 1, a);
      else fetch(a, r == 1, 1'b0);
    end
`ifdef L1I_PERF_CNT_EN
    chk("cnt_hit_rand", hit_cnt_o, exp_hits);
    chk("cnt_miss_rand", miss_cnt_o, exp_misses);
`endif

    // Reset at beat 2 of a refill
    ack_always = 1'b1;
    flush_pulse(1'b0, 32'h0);
    @(negedge clk);
    pc_re_i = 1'b1; pc_raddr_i = 32'h100;
    acked.delete();
    @(negedge clk);
    pc_re_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_memreq", {31'd0, mem_if.mem_req_o}, 0);
    chk("arst_stall", {31'd0, pc_stall_o}, 0);
    chk("arst_valid", {31'd0, pc_valid_o}, 0);
    chk("arst_memaddr", mem_if.mem_addr_o, 0);
`ifdef L1I_PERF_CNT_EN
    chk("arst_cnt", hit_cnt_o | miss_cnt_o, 0);
`endif
    $display("reset at beat 2 memreq=%0d stall=%0d", mem_if.mem_req_o, pc_stall_o);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    exp_hits = 0;
    exp_misses = 0;
    fetch(32'h100, 1'b0, 1'b0);
    fetch(32'h104, 1'b0, 1'b0);
`ifdef L1I_PERF_CNT_EN
    chk("cnt_hit_end", hit_cnt_o, exp_hits);
    chk("cnt_miss_end", miss_cnt_o, exp_misses);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=0", 1);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/l1i_cache.md
L1I_CACHE -- requirements
Module: l1i_cache

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have ports: clk  in  1  clock; all state changes on posedge.
REQ-004 SHALL have: rst  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have: hold_flag_i  in  1  pipeline hold; jump_flag_i  in  1  pipeline redirect; flush_i  in  1  invalidate all lines.
REQ-006 SHALL have: pc_re_i  in  1  fetch request; pc_raddr_i  in  32  fetch byte address (bits [1:0] ignored).
REQ-007 SHALL have: pc_rdata_o  out  32  instruction; pc_raddr_o  out  32  its address; pc_valid_o  out  1  output valid; pc_stall_o  out  1  refill in progress.
REQ-008 SHALL have: mem_req_o  out  1; mem_addr_o  out  32; mem_ack_i  in  1; mem_rdata_i  in  32 -- backing-memory word handshake.

Function
REQ-009 Address split SHALL be: word offset [log2(LINE_WORDS)+1:2], index next log2(SETS) bits, tag remaining upper bits.
REQ-010 States SHALL be IDLE, REFILL, RESP.
REQ-011 IDLE, pc_re_i=1, hold/jump/flush=0, hit: next cycle pc_rdata_o=word, pc_raddr_o=pc_raddr_i, pc_valid_o=1 (1-cycle latency).
REQ-012 IDLE, miss: latch address internally, go REFILL; pc_stall_o=1 from next cycle until RESP exit; requester need not hold pc_raddr_i.
REQ-013 REFILL: mem_req_o=1, mem_addr_o=line base+4*beat, beat from 0; beat increments on each cycle with mem_ack_i=1, word written to data array.
REQ-014 mem_addr_o SHALL be stable while mem_req_o=1 and mem_ack_i=0; mem_req_o SHALL drop the cycle after the last ack.
REQ-015 After last beat: tag written, valid set, go RESP; RESP outputs the missed word with pc_valid_o=1 for one cycle, then IDLE.
REQ-016 hold_flag_i or jump_flag_i in any cycle: next-cycle pc_rdata_o, pc_raddr_o=0, pc_valid_o=0; no lookup started in IDLE.
REQ-017 jump_flag_i during REFILL: refill completes and line is installed; RESP output suppressed (pc_valid_o=0).
REQ-018 pc_valid_o=0 implies pc_rdata_o=pc_raddr_o=0.
REQ-019 flush_i in IDLE: all valid bits cleared in one cycle; takes priority over a same-cycle pc_re_i, which is not serviced.
REQ-020 flush_i outside IDLE: recorded pending; applied on IDLE entry, also invalidating the just-refilled line.

Reset
REQ-021 rst=0 SHALL immediately force: state IDLE, all valid bits 0, beat 0, flush pending 0, all outputs 0 (including mem_req_o, pc_stall_o).
REQ-022 Reset mid-refill SHALL abort the refill; tag/data arrays are not reset.

Configuration
REQ-023 With L1I_PERF_CNT_EN defined: outputs hit_cnt_o, miss_cnt_o (32 bits each, reset 0, wrap at 2^32) count serviced hits and refills started.
REQ-024 Without L1I_PERF_CNT_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification (SETS=64, LINE_WORDS=4)
REQ-025 Cold read 0x100 -> beats 0x100,0x104,0x108,0x10C acked with 0xA0..0xA3 -> pc_rdata_o=0xA0, pc_raddr_o=0x100, pc_valid_o=1, pc_stall_o falls.
REQ-026 Then read 0x108 -> next cycle pc_rdata_o=0xA2, valid, no mem_req_o; hit_cnt_o=1, miss_cnt_o=1 with macro.
REQ-027 Read 0x500 (same index) -> refill; then read 0x100 -> refill again (eviction).
REQ-028 jump_flag_i=1 during beat 1 of 0x200 miss -> no valid RESP; then read 0x204 hits in 1 cycle.
REQ-029 flush_i pulse, then read 0x100 -> miss and refill; flush during REFILL -> line refilled then invalid, next read misses.
REQ-030 rst=0 at beat 2 -> mem_req_o, pc_stall_o, pc_valid_o 0 immediately; after release read 0x100 misses.
